mem_display_arbiter: RTL and testbench

Owns the single DataMemory port and shares it between the CPU and the seven-segment readout path. While the program runs, the CPU has the port transparently. Once finishExecution is seen, the block drains any CPU write, freezes the CPU, and steps a word address through memory on each debounced ShowNext press. Each fetched word's low 16 bits are latched for scan_output.

---
 rtl/mem_display_pkg.sv | 36 +++
 rtl/mem_display_arbiter_debounce.sv | 59 +++++
 rtl/mem_display_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_display_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_display_pkg.sv
// ---------------------------------------------------------------------------
// mem_display_pkg
// Shared types and constants for the DataMemory display arbiter.
//   disp_state_e        : arbiter FSM state encoding (2 bits)
//   WORD_BYTES          : bytes per memory word
//   DEFAULT_*           : default display address window and stride
//   is_word_aligned()   : true when an address sits on a word boundary
//   next_disp_addr()    : advance a display address with wrap at the limit
// ---------------------------------------------------------------------------
package mem_display_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FETCH = 2'd2,
        SHOW  = 2'd3
    } disp_state_e;

    localparam int unsigned WORD_BYTES = 4;

    localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h0000_0004;
    localparam logic [31:0] DEFAULT_STEP       = 32'h0000_0004;
    localparam logic [31:0] DEFAULT_LIMIT_ADDR = 32'h0000_03FC;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr % 32'(WORD_BYTES)) == 32'd0;
    endfunction

    function automatic logic [31:0] next_disp_addr(input logic [31:0] cur,
                                                   input logic [31:0] base,
                                                   input logic [31:0] step,
                                                   input logic [31:0] limit);
        return (cur == limit) ? base : cur + step;
    endfunction

endpackage

// File: rtl/mem_display_arbiter_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Two-flop synchronizer, stability counter and rising-edge pulse for a raw
// push-button level.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   btn_raw  : raw button level, asynchronous to clk
//   btn_rise : one-cycle pulse on each accepted 0->1 transition
// The accepted level flips only after DEBOUNCE_CYCLES consecutive
// synchronized samples that differ from it.
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_rise
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bad_cycles
            $error("button_debounce: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic          btn_meta;
    logic          btn_sync;
    logic          btn_stable;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            btn_stable <= 1'b0;
            stable_cnt <= '0;
            btn_rise   <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            btn_rise <= 1'b0;
            if (btn_sync == btn_stable) begin
                // Any sample agreeing with the accepted level restarts the run.
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                btn_stable <= btn_sync;
                stable_cnt <= '0;
                btn_rise   <= btn_sync;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_display_arbiter.sv
// ---------------------------------------------------------------------------
// mem_display_arbiter
// Owns the single DataMemory port. In RUN the CPU bus passes straight
// through. After finishExecution the block lets one in-flight CPU write
// complete (DRAIN), stalls the CPU and walks a word address through memory,
// one word per debounced ShowNext press, latching word[15:0] for display.
//
// Optional feature macro: DISPLAY_AUTO_STEP_EN
//   defined   -> an internal step also fires every AUTO_PERIOD cycles in SHOW
//   undefined -> only show_next advances the display
//
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   finish, show_next      : asynchronous finish level and raw button
//   cpu_mem_read/write     : CPU request strobes
//   cpu_addr, cpu_wdata    : CPU byte address / write data
//   cpu_rdata, cpu_stall   : read data to CPU (0 when not owning), stall flag
//   mem_read/write         : DataMemory strobes
//   mem_addr, mem_wdata    : DataMemory address / write data
//   mem_rdata              : DataMemory combinational read data
//   disp_data/addr/valid   : latched display word, its address, valid flag
// ---------------------------------------------------------------------------
module mem_display_arbiter
    import mem_display_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
    parameter logic [31:0] STEP            = DEFAULT_STEP,
    parameter logic [31:0] LIMIT_ADDR      = DEFAULT_LIMIT_ADDR,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned AUTO_PERIOD     = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        finish,
    input  logic        show_next,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] disp_data,
    output logic [31:0] disp_addr,
    output logic        disp_valid
);

    generate
        if (!is_word_aligned(BASE_ADDR) || !is_word_aligned(STEP) ||
            !is_word_aligned(LIMIT_ADDR)) begin : g_align_err
            $error("mem_display_arbiter: BASE_ADDR, STEP and LIMIT_ADDR must be word aligned");
        end
        if (AUTO_PERIOD == 0) begin : g_period_err
            $error("mem_display_arbiter: AUTO_PERIOD must be nonzero");
        end
    endgenerate

    disp_state_e state;

    logic finish_meta;
    logic finish_sync;
    logic btn_step;
    logic step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            finish_meta <= 1'b0;
            finish_sync <= 1'b0;
        end else begin
            finish_meta <= finish;
            finish_sync <= finish_meta;
        end
    end

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_show_next_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (show_next),
        .btn_rise(btn_step)
    );

`ifdef DISPLAY_AUTO_STEP_EN
    localparam logic [31:0] AUTO_LAST = 32'(AUTO_PERIOD - 1);

    logic [31:0] auto_cnt;
    logic        auto_step;

    assign auto_step = (state == SHOW) && (auto_cnt == AUTO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_cnt <= '0;
        end else if ((state != SHOW) || step) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 32'd1;
        end
    end

    assign step = btn_step | auto_step;
`else
    assign step = btn_step;
`endif

    // Bus ownership: CPU owns the port in RUN and DRAIN; everywhere else the
    // display path owns it and CPU writes are silently dropped.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = disp_addr;
        mem_wdata = '0;
        cpu_rdata = '0;
        cpu_stall = 1'b1;
        unique case (state)
            RUN, DRAIN: begin
                mem_read  = cpu_mem_read;
                mem_write = cpu_mem_write;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_rdata = mem_rdata;
                cpu_stall = (state != RUN);
            end
            FETCH: begin
                mem_read = 1'b1;
            end
            SHOW: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            disp_addr  <= BASE_ADDR;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (finish_sync) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    disp_addr <= BASE_ADDR;
                    state     <= FETCH;
                end
                FETCH: begin
                    disp_data  <= mem_rdata[15:0];
                    disp_valid <= 1'b1;
                    state      <= SHOW;
                end
                SHOW: begin
                    if (step) begin
                        disp_addr <= next_disp_addr(disp_addr, BASE_ADDR, STEP, LIMIT_ADDR);
                        state     <= FETCH;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_display_arbiter
// Directed bench for mem_display_arbiter with a behavioural DataMemory.
// Expected display words are queued when a step is requested and checked on
// the cycle after each display-side fetch.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_display_arbiter;

    localparam int unsigned DB = 16;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        finish;
    logic        show_next;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] disp_data;
    logic [31:0] disp_addr;
    logic        disp_valid;

    logic [31:0] mem [0:255];
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        chk_next = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_fetch = 0;
    int          fetch0;
    logic [31:0] tmpw;

    mem_display_arbiter #(
        .BASE_ADDR      (32'h0000_0004),
        .STEP           (32'h0000_0004),
        .LIMIT_ADDR     (32'h0000_03FC),
        .DEBOUNCE_CYCLES(DB),
        .AUTO_PERIOD    (1000000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .finish       (finish),
        .show_next    (show_next),
        .cpu_mem_read (cpu_mem_read),
        .cpu_mem_write(cpu_mem_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .disp_data    (disp_data),
        .disp_addr    (disp_addr),
        .disp_valid   (disp_valid)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_write && (mem_addr < 32'd1024)) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        logic [31:0] w;
        w = mem[a[9:2]];
        e.addr = a;
        e.data = w[15:0];
        exp_q.push_back(e);
    endtask

    task automatic press();
        show_next = 1'b1;
        repeat (DB + 6) @(negedge clk);
        show_next = 1'b0;
        repeat (DB + 6) @(negedge clk);
    endtask

    // Scoreboard: the cycle after a display fetch, the latched word must
    // match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                chk("sb_entry_present", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("sb_disp_addr", disp_addr, mon_e.addr);
                    chk("sb_disp_data", 32'(disp_data), 32'(mon_e.data));
                    chk("sb_disp_valid", 32'(disp_valid), 32'd1);
                end
            end
            chk_next = cpu_stall && mem_read;
            if (chk_next) n_fetch++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i * 7 + 3)};
        mem[1]   = 32'h0000_ABCD;
        mem[2]   = 32'h0000_1234;
        mem[3]   = 32'h0000_5678;
        mem[255] = 32'h7777_0FED;

        reset = 1'b0; finish = 1'b0; show_next = 1'b0;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_disp_addr", disp_addr, 32'h4);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_disp_data", 32'(disp_data), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);

        // RUN pass-through
        reset = 1'b1; cpu_addr = 32'h10; cpu_mem_write = 1'b1; cpu_wdata = 32'h1111_2222;
        #1;
        chk("run_mem_addr", mem_addr, 32'h10);
        chk("run_mem_write", 32'(mem_write), 32'd1);
        chk("run_mem_wdata", mem_wdata, 32'h1111_2222);
        @(negedge clk);
        cpu_mem_write = 1'b0; cpu_mem_read = 1'b1; cpu_addr = 32'h8;
        #1;
        chk("run_cpu_rdata", cpu_rdata, 32'h0000_1234);
        chk("run_mem_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        cpu_mem_read = 1'b0;

        // finish with a pending CPU write
        push_exp(32'h4);
        cpu_mem_write = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFE_F00D; finish = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cpu_stall) break;
        end
        chk("drain_reached", 32'(cpu_stall), 32'd1);
        chk("drain_mem_write", 32'(mem_write), 32'd1);
        chk("drain_mem_addr", mem_addr, 32'h20);
        @(negedge clk);
        cpu_wdata = 32'hBAD0_BAD0;
        #1;
        chk("fetch_mem_read", 32'(mem_read), 32'd1);
        chk("fetch_mem_write", 32'(mem_write), 32'd0);
        chk("fetch_mem_addr", mem_addr, 32'h4);
        chk("fetch_cpu_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        chk("show_disp_data", 32'(disp_data), 32'h0000_ABCD);
        @(negedge clk);
        tmpw = mem[8];
        chk("drain_write_landed", tmpw, 32'hCAFE_F00D);
        cpu_mem_write = 1'b0; finish = 1'b0;
        repeat (5) @(negedge clk);
        chk("finish_drop_stall", 32'(cpu_stall), 32'd1);
        chk("show_mem_read", 32'(mem_read), 32'd0);

        // two button steps
        push_exp(32'h8);
        press();
        chk("step1_addr", disp_addr, 32'h8);
        chk("step1_data", 32'(disp_data), 32'h1234);
        push_exp(32'hC);
        press();
        chk("step2_addr", disp_addr, 32'hC);
        chk("step2_data", 32'(disp_data), 32'h5678);

        // bounce rejection
        fetch0 = n_fetch;
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) show_next = ~show_next;
            @(negedge clk);
        end
        show_next = 1'b0;
        repeat (DB + 6) @(negedge clk);
        chk("bounce_no_fetch", 32'(n_fetch), 32'(fetch0));
        chk("bounce_addr", disp_addr, 32'hC);

        // walk to the limit, then wrap
        for (int unsigned a = 32'h10; a <= 32'h3FC; a += 4) begin
            push_exp(a);
            press();
        end
        chk("limit_addr", disp_addr, 32'h3FC);
        chk("limit_data", 32'(disp_data), 32'h0FED);
        push_exp(32'h4);
        press();
        chk("wrap_addr", disp_addr, 32'h4);
        chk("wrap_data", 32'(disp_data), 32'hABCD);

        // reset in the middle of a fetch
        push_exp(32'h8);
        show_next = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_read && cpu_stall) break;
        end
        chk("midfetch_reached", 32'(mem_read), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_disp_valid", 32'(disp_valid), 32'd0);
        chk("midrst_mem_read", 32'(mem_read), 32'd0);
        chk("midrst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("midrst_disp_addr", disp_addr, 32'h4);
        chk("midrst_disp_data", 32'(disp_data), 32'd0);
        exp_q.delete();
        show_next = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // steps in RUN are dropped
        fetch0 = n_fetch;
        press();
        chk("run_step_stall", 32'(cpu_stall), 32'd0);
        chk("run_step_no_fetch", 32'(n_fetch), 32'(fetch0));
        chk("run_step_valid", 32'(disp_valid), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
